mux2_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream valid/ready channel between two packet requesters. It drives the select of the team's 2:1 datapath mux. It holds a grant for a whole packet, or until a burst limit forces a switch, and exposes the registered select so other shared 2:1 muxes can be steered from it.

---
 rtl/mux2_arbiter.sv | 134 +++++++++++++
 tb/tb_mux2_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
// Round-robin arbiter sharing one downstream valid/ready channel between two
// packet requesters. A grant is held for a whole packet. A grant can also end
// when a burst limit forces a switch to a waiting requester. The registered
// select is exported so other shared 2:1 muxes can follow the same choice.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid[1:0]        per-requester beat valid (bit k = requester k)
//   req_last[1:0]         per-requester last-beat flag
//   req_data0/req_data1   requester beat data
//   req_ready[1:0]        per-requester accept
//   out_valid/out_data/out_last/out_ready   downstream channel
//   grant[1:0]            one-hot registered grant, 00 when idle
//   sel                   registered mux select (current/most recent grant)
//   busy                  1 while a grant is held
//   fsm_state[1:0]        arbiter state (0 idle, 1 grant0, 2 grant1)
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on the same channel. Valid does not depend on ready. Ready from the arbiter
// is the downstream ready passed through to the granted requester only.
// Both valid and ready are forced low while reset is high.

module mux2_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             sel,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  // Count value of the final beat allowed in one burst (beat_cnt+1 == MAX_BURST).
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          sel_n;
  logic          last_grant, last_grant_n;
  logic [CW-1:0] beat_cnt, beat_cnt_n;
  logic          pick;
  logic          other;
  logic          accept;
  logic          ready_bit;

  // In a grant state sel always equals the granted index.
  assign other  = ~sel;
  assign accept = req_valid[sel] & out_ready;

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    last_grant_n = last_grant;
    beat_cnt_n   = beat_cnt;
    pick         = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          // Both waiting: alternate away from the most recent grant.
          pick         = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
          state_n      = pick ? GRANT1 : GRANT0;
          sel_n        = pick;
          last_grant_n = pick;
          beat_cnt_n   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (accept) begin
          if (req_last[sel] || (beat_cnt == BURST_LAST)) begin
            if (req_valid[other]) begin
              // Release or preemption straight to the waiting requester.
              state_n      = other ? GRANT1 : GRANT0;
              sel_n        = other;
              last_grant_n = other;
              beat_cnt_n   = '0;
            end else if (req_last[sel]) begin
              state_n    = IDLE;
              beat_cnt_n = '0;
            end else begin
              // Burst limit reached but nobody is waiting: start a new burst.
              beat_cnt_n = '0;
            end
          end else begin
            beat_cnt_n = beat_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
    end
  end

  assign grant     = {state == GRANT1, state == GRANT0};
  assign busy      = |grant;
  assign fsm_state = state;

  assign out_data  = sel ? req_data1 : req_data0;
  assign out_last  = req_last[sel];
  assign out_valid = ~reset & busy & req_valid[sel];
  assign ready_bit = ~reset & busy & out_ready;
  assign req_ready = sel ? {ready_bit, 1'b0} : {1'b0, ready_bit};

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;
  localparam int W  = 32;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [1:0]   req_valid, req_last, req_ready, grant, fsm_state;
  logic [W-1:0] req_data0, req_data1, out_data;
  logic         out_valid, out_last, out_ready, sel, busy;

  mux2_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .grant(grant), .sel(sel), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  int beats       = 0;
  logic [W:0] src_q0[$];   // {last, data} beats still to be offered by requester 0
  logic [W:0] src_q1[$];
  logic [W:0] exp_q[$];    // expected downstream beats in order
  logic [1:0] grant_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_src(input int k, input logic [W-1:0] d, input logic l);
    if (k == 0) src_q0.push_back({l, d});
    else        src_q1.push_back({l, d});
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Present the head of each source queue, then let combinational outputs settle.
  task automatic settle();
    logic [W:0] h0, h1;
    h0 = (src_q0.size() != 0) ? src_q0[0] : '0;
    h1 = (src_q1.size() != 0) ? src_q1[0] : '0;
    req_valid = {src_q1.size() != 0, src_q0.size() != 0};
    req_data0 = h0[W-1:0];
    req_data1 = h1[W-1:0];
    req_last  = {h1[W], h0[W]};
    #1;
  endtask

  // Score the downstream beat, retire accepted source beats, advance one clock.
  task automatic finish_cycle();
    logic [W:0] e;
    if (out_valid && out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'({out_last, out_data}), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({out_last, out_data}), 64'(e));
      end
    end
    if (busy && (grant_log.size() == 0 || grant_log[grant_log.size()-1] != grant))
      grant_log.push_back(grant);
    if (req_valid[0] && req_ready[0]) void'(src_q0.pop_front());
    if (req_valid[1] && req_ready[1]) void'(src_q1.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    finish_cycle();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    req_valid = 2'b00;
    req_last  = 2'b00;
    req_data0 = '0;
    req_data1 = '0;
    @(negedge clk);

    // Reset held two cycles with both requesters valid; then single-beat packets.
    push_src(0, 32'hB0, 1'b1);
    push_src(1, 32'hC1, 1'b1);
    push_exp(32'hB0, 1'b1);
    push_exp(32'hC1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      finish_cycle();
    end
    reset = 1'b0;
    settle();
    check("post_rst_grant", 64'(grant), 64'd0);
    check("post_rst_sel", 64'(sel), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_state", 64'(fsm_state), 64'd0);
    finish_cycle();
    settle();
    check("both_first_grant", 64'(grant), 64'b01);
    check("both_first_data", 64'(out_data), 64'hB0);
    finish_cycle();
    settle();
    check("both_second_grant", 64'(grant), 64'b10);
    check("both_second_sel", 64'(sel), 64'd1);
    finish_cycle();
    settle();
    check("both_idle_busy", 64'(busy), 64'd0);
    check("idle_sel_hold", 64'(sel), 64'd1);
    finish_cycle();
    check("both_drained", 64'(exp_q.size()), 64'd0);

    // Requester 0: three-beat packet.
    push_src(0, 32'hA1, 1'b0);
    push_src(0, 32'hA2, 1'b0);
    push_src(0, 32'hA3, 1'b1);
    push_exp(32'hA1, 1'b0);
    push_exp(32'hA2, 1'b0);
    push_exp(32'hA3, 1'b1);
    settle();
    check("pkt0_req_grant", 64'(grant), 64'd0);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("pkt0_grant", 64'(grant), 64'b01);
      finish_cycle();
    end
    settle();
    check("pkt0_end_busy", 64'(busy), 64'd0);
    check("pkt0_end_grant", 64'(grant), 64'd0);
    finish_cycle();
    check("pkt0_drained", 64'(exp_q.size()), 64'd0);

    // Requester 1 stalled by downstream for two cycles mid-packet.
    push_src(1, 32'hD0, 1'b0);
    push_src(1, 32'hD1, 1'b0);
    push_src(1, 32'hD2, 1'b1);
    push_exp(32'hD0, 1'b0);
    push_exp(32'hD1, 1'b0);
    push_exp(32'hD2, 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_data", 64'(out_data), 64'hD1);
      check("stall_grant", 64'(grant), 64'b10);
      finish_cycle();
    end
    out_ready = 1'b1;
    settle();
    check("resume_req_ready", 64'(req_ready), 64'b10);
    finish_cycle();
    run_until_drained("stall_drain", 10);
    tick();

    // Burst limit: 10-beat packet on 0, 2-beat packet pending on 1.
    for (int i = 0; i < 10; i++) push_src(0, 32'hE0 + 32'(i), (i == 9));
    push_src(1, 32'hF0, 1'b0);
    push_src(1, 32'hF1, 1'b1);
    for (int i = 0; i < 4; i++) push_exp(32'hE0 + 32'(i), 1'b0);
    push_exp(32'hF0, 1'b0);
    push_exp(32'hF1, 1'b1);
    for (int i = 4; i < 10; i++) push_exp(32'hE0 + 32'(i), (i == 9));
    beats = 0;
    grant_log.delete();
    run_until_drained("burst_drain", 40);
    check("burst_beats", 64'(beats), 64'd12);
    check("burst_grants", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) begin
      check("burst_g0", 64'(grant_log[0]), 64'b01);
      check("burst_g1", 64'(grant_log[1]), 64'b10);
      check("burst_g2", 64'(grant_log[2]), 64'b01);
    end
    settle();
    check("burst_end_busy", 64'(busy), 64'd0);
    finish_cycle();

    // Reset after beat 2 of a 5-beat packet from requester 1.
    for (int i = 0; i < 5; i++) push_src(1, 32'h60 + 32'(i), (i == 4));
    push_exp(32'h60, 1'b0);
    push_exp(32'h61, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    settle();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    finish_cycle();
    reset = 1'b0;
    src_q1.delete();
    check("midrst_drained", 64'(exp_q.size()), 64'd0);
    settle();
    check("midrst_state", 64'(fsm_state), 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_sel", 64'(sel), 64'd0);
    finish_cycle();
    push_src(0, 32'h70, 1'b1);
    push_src(1, 32'h71, 1'b1);
    push_exp(32'h70, 1'b1);
    push_exp(32'h71, 1'b1);
    settle();
    check("rearb_idle", 64'(grant), 64'd0);
    finish_cycle();
    settle();
    check("rearb_first", 64'(grant), 64'b01);
    finish_cycle();
    settle();
    check("rearb_second", 64'(grant), 64'b10);
    finish_cycle();
    settle();
    check("rearb_idle_end", 64'(grant), 64'd0);
    finish_cycle();
    check("rearb_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
